// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the key-schedule engine.
// Optional round-key storage in the top level is enabled with AES_RK_STORE_EN.
package aes_pkg;

    typedef logic [0:31]  word_t;
    typedef logic [0:127] block_t;

    localparam int         AES128_NR = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four AES S-boxes over the bytes of a 32-bit key word.
// The S-box is derived arithmetically (GF inverse followed by the affine map).
module aes_sbox
    import aes_pkg::*;
(
    input  logic [3:0] hi_i,
    input  logic [3:0] lo_i,
    output logic [7:0] s_o
);

    localparam logic [7:0] INV_EXP = 8'hFE;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            else      acc = acc;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (INV_EXP[i]) r = gf_mul(r, p);
            else            r = r;
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    logic [7:0] inv_s;

    assign inv_s = gf_inv({hi_i, lo_i});
    assign s_o   = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
                 ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;

endmodule

module sub_word
    import aes_pkg::*;
(
    input  word_t w_i,
    output word_t w_o
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        logic [7:0] b_s;
        logic [7:0] s_s;
        assign b_s = w_i[8*i +: 8];
        aes_sbox u_sbox (
            .hi_i (b_s[7:4]),
            .lo_i (b_s[3:0]),
            .s_o  (s_s)
        );
        assign w_o[8*i +: 8] = s_s;
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule streaming round keys 0..10 over valid/ready.
// Define AES_RK_STORE_EN to add an 11-entry round-key store with a read port.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NR    = AES128_NR,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [0:KEY_W-1] key_in,
    output logic [0:KEY_W-1] rk_out,
    output logic [3:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
`ifdef AES_RK_STORE_EN
    input  logic [3:0]       rd_idx,
    output logic [0:KEY_W-1] rd_key,
`endif
    output logic             busy,
    output logic             done
);

    state_e     state_q, state_d;
    block_t     rk_q, rk_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] rcon_q, rcon_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    word_t  rot_s, sub_s, t_s, w0_s, w1_s, w2_s, w3_s;
    block_t next_key_s;
    logic   xfer_s;
    logic   accept_s;

    assign rot_s = {rk_q[104:127], rk_q[96:103]};

    sub_word u_sub_word (
        .w_i (rot_s),
        .w_o (sub_s)
    );

    assign t_s        = sub_s ^ {rcon_q, 24'h000000};
    assign w0_s       = rk_q[0:31]   ^ t_s;
    assign w1_s       = rk_q[32:63]  ^ w0_s;
    assign w2_s       = rk_q[64:95]  ^ w1_s;
    assign w3_s       = rk_q[96:127] ^ w2_s;
    assign next_key_s = {w0_s, w1_s, w2_s, w3_s};

    assign xfer_s   = (state_q == ST_EMIT) && valid_q && rk_ready;
    assign accept_s = (state_q == ST_IDLE) && start;

    // Next-state and output-register computation for the expansion FSM.
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rk_d    = key_in;
                    idx_d   = 4'd0;
                    rcon_d  = RCON_INIT;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (xfer_s && (idx_q == 4'(NR))) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else if (xfer_s) begin
                    rk_d   = next_key_s;
                    idx_d  = idx_q + 4'd1;
                    rcon_d = xtime(rcon_q);
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything so no partial key leaks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            idx_q   <= 4'd0;
            rcon_q  <= RCON_INIT;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rk_out   = rk_q;
    assign rk_idx   = idx_q;
    assign rk_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef AES_RK_STORE_EN
    block_t        store_q [0:NR];
    logic [NR:0]   written_q;

    // Capture each key as it is transferred; a new start invalidates old entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
        end else if (accept_s) begin
            written_q <= '0;
        end else if (xfer_s) begin
            store_q[idx_q]   <= rk_q;
            written_q[idx_q] <= 1'b1;
        end else begin
            written_q <= written_q;
        end
    end

    assign rd_key = ((rd_idx <= 4'(NR)) && written_q[rd_idx]) ? store_q[rd_idx] : '0;
`else
    logic unused_accept_s;
    assign unused_accept_s = accept_s;
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq using FIPS-197 and all-zero key vectors.
// Build with AES_RK_STORE_EN defined to also exercise the round-key store.
module tb_aes_key_expand_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [0:127] key_in;
    logic [0:127] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;
`ifdef AES_RK_STORE_EN
    logic [3:0]   rd_idx;
    logic [0:127] rd_key;
`endif

    int checks;
    int errors;

    logic [0:127] fips_rk [0:10];
    logic [0:127] cap_key [0:10];
    logic [10:0]  cap_got;
    int           done_cycle;
    int           done_cnt;
    int           held_bad;
    int           stall_cnt;
    logic         end_busy;
    logic         end_valid;

    localparam logic [0:127] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] ZERO_KEY  = 128'h0;
    localparam logic [0:127] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    aes_key_expand_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
`ifdef AES_RK_STORE_EN
        .rd_idx   (rd_idx),
        .rd_key   (rd_key),
`endif
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an expansion and observe 30 cycles; optionally stall at one index
    // and pulse start (with another key) while a given index is presented.
    task automatic run_expand(input logic [0:127] key, input int stall_idx, input int stall_len,
                              input int inj_idx, input logic [0:127] inj_key);
        logic [0:127] held_key;
        logic [3:0]   held_idx;
        logic         injected;
        cap_got    = 11'd0;
        done_cycle = -1;
        done_cnt   = 0;
        held_bad   = 0;
        stall_cnt  = 0;
        injected   = 1'b0;
        held_key   = 128'h0;
        held_idx   = 4'd0;
        @(negedge clk);
        key_in   = key;
        start    = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = ~key;
        for (int c = 1; c <= 30; c++) begin
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (rk_valid && (int'(rk_idx) == stall_idx) && (stall_cnt < stall_len)) begin
                if (stall_cnt == 0) begin
                    held_key = rk_out;
                    held_idx = rk_idx;
                end else if ((rk_out !== held_key) || (rk_idx !== held_idx)) begin
                    held_bad++;
                end
                stall_cnt++;
                rk_ready = 1'b0;
            end else begin
                rk_ready = 1'b1;
                if (rk_valid) begin
                    cap_key[rk_idx] = rk_out;
                    cap_got[rk_idx] = 1'b1;
                end
            end
            if (rk_valid && (int'(rk_idx) == inj_idx) && !injected) begin
                start    = 1'b1;
                key_in   = inj_key;
                injected = 1'b1;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        end_busy  = busy;
        end_valid = rk_valid;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = 128'h0;
        #12;
        checks++;
        if ({rk_valid, busy, done, rk_idx} !== 7'd0 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b busy=%b done=%b idx=%0d key=%h, required all zero",
                     rk_valid, busy, done, rk_idx, rk_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", rk_valid, busy);
        end
    endtask

    task automatic test_fips();
        run_expand(FIPS_KEY, -1, 0, -1, 128'h0);
        checks++;
        if (cap_got !== 11'h7FF) begin
            errors++;
            $display("FAIL fips_all_idx: got mask %b, required 11111111111", cap_got);
        end
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (cap_key[i] !== fips_rk[i]) begin
                errors++;
                $display("FAIL fips_rk%0d: got %h, required %h", i, cap_key[i], fips_rk[i]);
            end
        end
        checks++;
        if (done_cycle !== 12 || done_cnt !== 1) begin
            errors++;
            $display("FAIL fips_done: cycle %0d count %0d, required cycle 12 count 1", done_cycle, done_cnt);
        end
        checks++;
        if (end_busy !== 1'b0 || end_valid !== 1'b0) begin
            errors++;
            $display("FAIL fips_idle_after: busy=%b valid=%b, required 0 0", end_busy, end_valid);
        end
    endtask

    task automatic test_zero_key();
        run_expand(ZERO_KEY, -1, 0, -1, 128'h0);
        checks++;
        if (cap_key[0] !== ZERO_KEY) begin
            errors++;
            $display("FAIL zero_rk0: got %h, required %h", cap_key[0], ZERO_KEY);
        end
        checks++;
        if (cap_key[1] !== 128'h62636363626363636263636362636363) begin
            errors++;
            $display("FAIL zero_rk1: got %h, required 62636363626363636263636362636363", cap_key[1]);
        end
        checks++;
        if (cap_key[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++;
            $display("FAIL zero_rk10: got %h, required b4ef5bcb3e92e21123e951cf6f8f188e", cap_key[10]);
        end
    endtask

    task automatic test_backpressure();
        run_expand(FIPS_KEY, 3, 5, -1, 128'h0);
        checks++;
        if (stall_cnt !== 5 || held_bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: stalled %0d cycles with %0d changes, required 5 and 0", stall_cnt, held_bad);
        end
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (cap_key[i] !== fips_rk[i] || cap_got[i] !== 1'b1) begin
                errors++;
                $display("FAIL bp_rk%0d: got %h (seen %b), required %h", i, cap_key[i], cap_got[i], fips_rk[i]);
            end
        end
        checks++;
        if (done_cycle !== 17) begin
            errors++;
            $display("FAIL bp_done: cycle %0d, required 17", done_cycle);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        @(negedge clk);
        key_in   = FIPS_KEY;
        start    = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(rk_valid && rk_idx == 4'd5) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL rst_mid_reach: idx 5 not seen within 20 cycles, last idx %0d", rk_idx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rk_valid, busy, done, rk_idx} !== 7'd0 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL rst_mid_clear: valid=%b busy=%b done=%b idx=%0d key=%h, required all zero",
                     rk_valid, busy, done, rk_idx, rk_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_expand(FIPS_KEY, -1, 0, -1, 128'h0);
        checks++;
        if (cap_key[0] !== FIPS_KEY || cap_key[10] !== fips_rk[10] || done_cycle !== 12) begin
            errors++;
            $display("FAIL rst_mid_restart: rk0 %h rk10 %h done %0d, required %h %h 12",
                     cap_key[0], cap_key[10], done_cycle, FIPS_KEY, fips_rk[10]);
        end
    endtask

    task automatic test_start_ignored();
        run_expand(FIPS_KEY, -1, 0, 4, OTHER_KEY);
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (cap_key[i] !== fips_rk[i]) begin
                errors++;
                $display("FAIL ign4_rk%0d: got %h, required %h", i, cap_key[i], fips_rk[i]);
            end
        end
        run_expand(FIPS_KEY, -1, 0, 10, OTHER_KEY);
        checks++;
        if (end_busy !== 1'b0 || end_valid !== 1'b0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL ign10_idle: busy=%b valid=%b done_cnt=%0d, required 0 0 1", end_busy, end_valid, done_cnt);
        end
    endtask

`ifdef AES_RK_STORE_EN
    task automatic test_store();
        run_expand(FIPS_KEY, -1, 0, -1, 128'h0);
        rd_idx = 4'd10;
        #1;
        checks++;
        if (rd_key !== fips_rk[10]) begin
            errors++;
            $display("FAIL store_rd10: got %h, required %h", rd_key, fips_rk[10]);
        end
        rd_idx = 4'd0;
        #1;
        checks++;
        if (rd_key !== FIPS_KEY) begin
            errors++;
            $display("FAIL store_rd0: got %h, required %h", rd_key, FIPS_KEY);
        end
        rd_idx = 4'd12;
        #1;
        checks++;
        if (rd_key !== 128'h0) begin
            errors++;
            $display("FAIL store_rd12: got %h, required 0", rd_key);
        end
        @(negedge clk);
        key_in = ZERO_KEY;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        rd_idx = 4'd10;
        #1;
        checks++;
        if (rd_key !== 128'h0) begin
            errors++;
            $display("FAIL store_cleared: got %h, required 0", rd_key);
        end
        repeat (15) @(negedge clk);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
`ifdef AES_RK_STORE_EN
        rd_idx = 4'd0;
`endif
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        test_reset();
        test_fips();
        test_zero_key();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
`ifdef AES_RK_STORE_EN
        test_store();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
